// File: rtl/cam_capture_pkg.sv
// Shared types and width helpers for the camera capture front end.
package cam_capture_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VSYNC  = 2'd1,
        S_ACTIVE = 2'd2,
        S_SKIP   = 2'd3
    } state_t;

    function automatic int pix_w(input int data_w, input int bytes_per_pix);
        return data_w * bytes_per_pix;
    endfunction

    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/cam_pix_pack.sv
// Gathers BYTES_PER_PIX camera beats MSB-first into one pixel; o_vld is combinational on the final beat.
// No backpressure: a beat is consumed whenever i_vld is high; i_clr abandons a partial pixel.
module cam_pix_pack
    import cam_capture_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    localparam int PIX_W        = pix_w(DATA_W, BYTES_PER_PIX)
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_vld,
    input  logic              i_clr,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_vld,
    output logic [PIX_W-1:0]  o_pix
);

    localparam logic [1:0] LAST = 2'(BYTES_PER_PIX - 1);

    logic [1:0]       r_phase;
    logic [PIX_W-1:0] w_cat;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_phase <= '0;
        end else if (i_clr) begin
            r_phase <= '0;
        end else if (i_vld) begin
            r_phase <= (r_phase == LAST) ? 2'd0 : r_phase + 2'd1;
        end
    end

    generate
        if (BYTES_PER_PIX == 1) begin : g_single
            assign w_cat = i_data;
        end else begin : g_multi
            // Only the earlier beats are stored; the final beat joins straight from the pins.
            localparam int SR_W = PIX_W - DATA_W;
            logic [SR_W-1:0] r_sr;

            always_ff @(posedge i_clk or negedge i_rstn) begin
                if (!i_rstn) begin
                    r_sr <= '0;
                end else if (i_vld) begin
                    r_sr <= w_cat[SR_W-1:0];
                end
            end

            assign w_cat = {r_sr, i_data};
        end
    endgenerate

    assign o_vld = i_vld && (r_phase == LAST);
    assign o_pix = w_cat;

endmodule

// File: rtl/cam_capture_win.sv
// DVP capture with runtime crop window and frame decimation; pixel write 1 pclk after its final beat.
// i_full does not stall the camera: in-window pixels seen while full are discarded and flagged on o_drop.
module cam_capture_win
    import cam_capture_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int MAX_W         = 640,
    parameter int MAX_H         = 480,
    parameter int SKIP_W        = 4,
    localparam int PIX_W        = pix_w(DATA_W, BYTES_PER_PIX),
    localparam int CW           = cnt_w(MAX_W),
    localparam int RW           = cnt_w(MAX_H)
) (
    input  logic              i_pclk,
    input  logic              i_rstn,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_en,
    input  logic [CW-1:0]     i_x0,
    input  logic [CW-1:0]     i_w,
    input  logic [RW-1:0]     i_y0,
    input  logic [RW-1:0]     i_h,
    input  logic [SKIP_W-1:0] i_skip,
    input  logic              i_full,
    output logic              o_wr,
    output logic [PIX_W-1:0]  o_wdata,
    output logic              o_sof,
    output logic              o_eol,
    output logic              o_eof,
    output logic              o_drop,
    output logic [RW-1:0]     o_rows
);

    localparam logic [CW-1:0] XMAX = CW'(MAX_W);
    localparam logic [RW-1:0] YMAX = RW'(MAX_H);

    state_t            r_state, w_next;
    logic              r_vsync_d, r_href_d;
    logic [SKIP_W-1:0] r_skip_cnt;
    logic [CW-1:0]     r_x0, r_w, r_x;
    logic [RW-1:0]     r_y0, r_h, r_y, r_rows_cnt;
    logic              r_row_hit, r_sof_pend;

    logic              w_vs_rise, w_vs_fall, w_href_fall, w_active, w_start, w_capture;
    logic              w_beat, w_line_end, w_pix_vld, w_pix_in, w_wr, w_drop, w_last_col;
    logic              w_in_x, w_in_y;
    logic [PIX_W-1:0]  w_pix;
    logic [CW:0]       w_xe, w_xend;
    logic [RW:0]       w_ye, w_yend;

    assign w_vs_rise   = i_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~i_vsync & r_vsync_d;
    assign w_href_fall = ~i_href & r_href_d;
    assign w_active    = (r_state == S_ACTIVE);
    assign w_start     = (r_state == S_VSYNC) & w_vs_fall;
    assign w_capture   = i_en & (r_skip_cnt == '0);
    assign w_beat      = w_active & i_href & ~i_vsync;
    assign w_line_end  = w_active & w_href_fall & ~i_vsync;

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_vs_rise) w_next = S_VSYNC;
            S_VSYNC:  if (w_vs_fall) w_next = w_capture ? S_ACTIVE : S_SKIP;
            S_ACTIVE: if (w_vs_rise) w_next = S_VSYNC;
            S_SKIP:   if (w_vs_rise) w_next = S_VSYNC;
            default:  w_next = S_IDLE;
        endcase
    end

    // Edge history resets high so a vsync already high at reset release is not taken as a frame start.
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_vsync_d  <= 1'b1;
            r_href_d   <= 1'b0;
            r_skip_cnt <= '0;
            r_x0       <= '0;
            r_w        <= '0;
            r_y0       <= '0;
            r_h        <= '0;
        end else begin
            r_vsync_d <= i_vsync;
            r_href_d  <= i_href;
            if (w_start) begin
                r_x0 <= i_x0;
                r_w  <= i_w;
                r_y0 <= i_y0;
                r_h  <= i_h;
                if (w_capture) begin
                    r_skip_cnt <= i_skip;
                end else if (r_skip_cnt != '0) begin
                    r_skip_cnt <= r_skip_cnt - SKIP_W'(1);
                end
            end
        end
    end

    cam_pix_pack #(
        .DATA_W        (DATA_W),
        .BYTES_PER_PIX (BYTES_PER_PIX)
    ) u_pack (
        .i_clk  (i_pclk),
        .i_rstn (i_rstn),
        .i_vld  (w_beat),
        .i_clr  (~w_active | w_href_fall),
        .i_data (i_data),
        .o_vld  (w_pix_vld),
        .o_pix  (w_pix)
    );

    // Window bounds are widened one bit so x0+w / y0+h never wrap.
    assign w_xe       = {1'b0, r_x};
    assign w_xend     = {1'b0, r_x0} + {1'b0, r_w};
    assign w_ye       = {1'b0, r_y};
    assign w_yend     = {1'b0, r_y0} + {1'b0, r_h};
    assign w_in_x     = (w_xe >= {1'b0, r_x0}) && (w_xe < w_xend) && (r_x < XMAX);
    assign w_in_y     = (w_ye >= {1'b0, r_y0}) && (w_ye < w_yend) && (r_y < YMAX);
    assign w_pix_in   = w_pix_vld & w_in_x & w_in_y;
    assign w_wr       = w_pix_in & ~i_full;
    assign w_drop     = w_pix_in & i_full;
    assign w_last_col = ((w_xe + (CW+1)'(1)) == w_xend);

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_x        <= '0;
            r_y        <= '0;
            r_rows_cnt <= '0;
            r_row_hit  <= 1'b0;
        end else if (!w_active) begin
            r_x        <= '0;
            r_y        <= '0;
            r_rows_cnt <= '0;
            r_row_hit  <= 1'b0;
        end else if (w_line_end) begin
            r_x        <= '0;
            r_y        <= (r_y == YMAX) ? r_y : r_y + RW'(1);
            r_rows_cnt <= r_rows_cnt + {{(RW-1){1'b0}}, r_row_hit};
            r_row_hit  <= 1'b0;
        end else if (w_pix_vld) begin
            r_x <= (r_x == XMAX) ? r_x : r_x + CW'(1);
            if (w_pix_in) begin
                r_row_hit <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wr       <= 1'b0;
            o_wdata    <= '0;
            o_sof      <= 1'b0;
            o_eol      <= 1'b0;
            o_eof      <= 1'b0;
            o_drop     <= 1'b0;
            o_rows     <= '0;
            r_sof_pend <= 1'b0;
        end else begin
            o_wr  <= w_wr;
            o_sof <= w_wr & r_sof_pend;
            o_eol <= w_wr & w_last_col;
            o_eof <= w_active & w_vs_rise;
            if (w_wr) begin
                o_wdata <= w_pix;
            end
            if (w_start) begin
                r_sof_pend <= 1'b1;
            end else if (w_wr) begin
                r_sof_pend <= 1'b0;
            end
            if (w_wr & r_sof_pend) begin
                o_drop <= 1'b0;
            end else if (w_drop) begin
                o_drop <= 1'b1;
            end
            // A row still open when vsync rises counts if it already hit the window.
            if (w_active & w_vs_rise) begin
                o_rows <= r_rows_cnt + {{(RW-1){1'b0}}, r_row_hit};
            end
        end
    end

endmodule

// File: tb/tb_cam_capture_win.sv
// Directed bench for cam_capture_win: 2-byte and 3-byte pixel instances driven by one camera stream.
module tb_cam_capture_win;

    localparam int MW = 16;
    localparam int MH = 8;

    typedef struct packed {
        logic [31:0] dat;
        logic        sof;
        logic        eol;
    } rec_t;

    logic        clk = 1'b0;
    logic        rstn, vsync, href, en, full;
    logic [7:0]  data;
    logic [4:0]  x0, w;
    logic [3:0]  y0, h, skip;

    logic        wr2, sof2, eol2, eof2, drop2;
    logic [15:0] wdata2;
    logic [3:0]  rows2;
    logic        wr3, sof3, eol3, eof3, drop3;
    logic [23:0] wdata3;
    logic [3:0]  rows3;

    rec_t log2[$], log3[$], exp_q[$];
    int   n_sof2, n_eol2, n_eof2, n_eof3;
    int   n_total = 0, n_bad = 0;
    int   m_x0, m_w, m_y0, m_h, m_lines, m_dl, m_dp0, m_dp1;
    int   lb[8];

    always #5 clk = ~clk;

    cam_capture_win #(.DATA_W(8), .BYTES_PER_PIX(2), .MAX_W(MW), .MAX_H(MH), .SKIP_W(4)) u_dut (
        .i_pclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_href(href), .i_data(data),
        .i_en(en), .i_x0(x0), .i_w(w), .i_y0(y0), .i_h(h), .i_skip(skip), .i_full(full),
        .o_wr(wr2), .o_wdata(wdata2), .o_sof(sof2), .o_eol(eol2), .o_eof(eof2),
        .o_drop(drop2), .o_rows(rows2)
    );

    cam_capture_win #(.DATA_W(8), .BYTES_PER_PIX(3), .MAX_W(MW), .MAX_H(MH), .SKIP_W(4)) u_dut3 (
        .i_pclk(clk), .i_rstn(rstn), .i_vsync(vsync), .i_href(href), .i_data(data),
        .i_en(en), .i_x0(x0), .i_w(w), .i_y0(y0), .i_h(h), .i_skip(skip), .i_full(full),
        .o_wr(wr3), .o_wdata(wdata3), .o_sof(sof3), .o_eol(eol3), .o_eof(eof3),
        .o_drop(drop3), .o_rows(rows3)
    );

    always @(negedge clk) begin
        if (wr2) log2.push_back(rec_t'{dat: 32'(wdata2), sof: sof2, eol: eol2});
        if (wr3) log3.push_back(rec_t'{dat: 32'(wdata3), sof: sof3, eol: eol3});
        if (sof2) n_sof2++;
        if (eol2) n_eol2++;
        if (eof2) n_eof2++;
        if (eof3) n_eof3++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", n_total, n_bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bv(input int l, input int k);
        return 8'((l * 29 + k * 7 + 17) % 256);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vs_hi();
        vsync = 1'b1;
        repeat (4) tick();
    endtask

    task automatic vs_lo();
        vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic clear_logs();
        log2.delete();
        log3.delete();
        n_sof2 = 0; n_eol2 = 0; n_eof2 = 0; n_eof3 = 0;
    endtask

    task automatic set_cfg(input int ax0, input int aw, input int ay0, input int ah, input int askip);
        x0 = 5'(ax0); w = 5'(aw); y0 = 4'(ay0); h = 4'(ah); skip = 4'(askip);
        m_x0 = ax0; m_w = aw; m_y0 = ay0; m_h = ah;
    endtask

    // One camera line: nb byte beats; i_full held high during beats fs .. fs+fl-1.
    task automatic send_line(input int l, input int nb, input int fs, input int fl);
        for (int k = 0; k < nb; k++) begin
            href = 1'b1;
            data = bv(l, k);
            full = (k >= fs) && (k < fs + fl);
            tick();
        end
        href = 1'b0;
        full = 1'b0;
        data = 8'h00;
        repeat (3) tick();
    endtask

    task automatic build_exp(input int bpp);
        bit          first;
        logic [31:0] d;
        rec_t        r;
        exp_q.delete();
        first = 1'b1;
        for (int l = 0; l < m_lines; l++) begin
            for (int p = 0; p < lb[l] / bpp; p++) begin
                if (p < MW && l < MH && p >= m_x0 && p < m_x0 + m_w && l >= m_y0 && l < m_y0 + m_h
                    && !(l == m_dl && p >= m_dp0 && p <= m_dp1)) begin
                    d = '0;
                    for (int b = 0; b < bpp; b++) d = (d << 8) | 32'(bv(l, p * bpp + b));
                    r.dat = d;
                    r.sof = first;
                    r.eol = (p == m_x0 + m_w - 1);
                    first = 1'b0;
                    exp_q.push_back(r);
                end
            end
        end
    endtask

    task automatic cmp_log(input string tag, input rec_t got[$], input int bpp);
        int nb;
        build_exp(bpp);
        chk({tag, "_nwr"}, got.size(), exp_q.size());
        nb = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) nb++;
        chk({tag, "_recs"}, nb, 0);
    endtask

    initial begin
        rstn = 1'b1; vsync = 1'b0; href = 1'b0; data = '0; en = 1'b1; full = 1'b0;
        set_cfg(0, 16, 0, 8, 0);
        m_dl = -1; m_dp0 = 0; m_dp1 = 0; m_lines = 0;
        for (int l = 0; l < 8; l++) lb[l] = 32;
        clear_logs();
        #2 rstn = 1'b0;
        repeat (3) tick();
        chk("rst_flags", 32'({wr2, sof2, eol2, eof2, drop2}), 32'd0);
        chk("rst_wdata", 32'(wdata2), 32'd0);
        chk("rst_rows", 32'(rows2), 32'd0);
        rstn = 1'b1;
        repeat (2) tick();
        vs_hi();

        // full-frame capture
        set_cfg(0, 16, 0, 8, 0); clear_logs(); vs_lo();
        m_lines = 8;
        for (int l = 0; l < 8; l++) send_line(l, 32, 99, 0);
        vs_hi();
        cmp_log("full", log2, 2);
        chk("full_sof", n_sof2, 1);
        chk("full_eol", n_eol2, 8);
        chk("full_eof", n_eof2, 1);
        chk("full_rows", 32'(rows2), 8);

        // crop window x 4..11, rows 2..4
        set_cfg(4, 8, 2, 3, 0); clear_logs(); vs_lo();
        for (int l = 0; l < 8; l++) send_line(l, 32, 99, 0);
        vs_hi();
        cmp_log("crop", log2, 2);
        chk("crop_first", log2.size() > 0 ? log2[0].dat : 32'hDEAD_BEEF, {16'h0, bv(2, 8), bv(2, 9)});
        chk("crop_sof", n_sof2, 1);
        chk("crop_eol", n_eol2, 3);
        chk("crop_rows", 32'(rows2), 3);

        // decimation: capture one, drop two, over six frames
        set_cfg(0, 16, 0, 8, 2); clear_logs();
        for (int f = 0; f < 6; f++) begin
            vs_lo();
            send_line(0, 32, 99, 0);
            send_line(1, 32, 99, 0);
            vs_hi();
        end
        chk("skip_nwr", log2.size(), 64);
        chk("skip_sof", n_sof2, 2);
        chk("skip_eof", n_eof2, 2);
        chk("skip_rows", 32'(rows2), 2);

        // downstream full for 5 beats: pixels 5 and 6 of line 0 lost
        set_cfg(0, 16, 0, 8, 0); clear_logs(); vs_lo();
        m_lines = 2; m_dl = 0; m_dp0 = 5; m_dp1 = 6;
        send_line(0, 32, 10, 5);
        chk("full_drop_mid", 32'(drop2), 1);
        send_line(1, 32, 99, 0);
        vs_hi();
        cmp_log("bp", log2, 2);
        chk("bp_drop_end", 32'(drop2), 1);
        chk("bp_eol", n_eol2, 2);
        m_dl = -1;

        // odd beat count on line 0: partial pixel discarded
        clear_logs(); vs_lo();
        chk("drop_held", 32'(drop2), 1);
        m_lines = 2; lb[0] = 3; lb[1] = 32;
        send_line(0, 3, 99, 0);
        send_line(1, 32, 99, 0);
        vs_hi();
        cmp_log("odd", log2, 2);
        chk("odd_drop_clr", 32'(drop2), 0);
        chk("odd_eol", n_eol2, 1);
        chk("odd_rows", 32'(rows2), 2);
        lb[0] = 32;

        // reset mid-row, released with vsync low
        vs_lo();
        for (int k = 0; k < 9; k++) begin
            href = 1'b1; data = bv(0, k); tick();
        end
        rstn = 1'b0;
        tick();
        chk("mid_rst_flags", 32'({wr2, sof2, eol2, eof2, drop2}), 32'd0);
        chk("mid_rst_rows", 32'(rows2), 32'd0);
        clear_logs();
        tick();
        rstn = 1'b1;
        for (int k = 9; k < 17; k++) begin
            data = bv(0, k); tick();
        end
        href = 1'b0;
        repeat (3) tick();
        send_line(1, 32, 99, 0);
        vs_hi();
        chk("post_rst_nwr", log2.size(), 0);
        chk("post_rst_eof", n_eof2, 0);
        vs_lo();
        m_lines = 1;
        send_line(0, 32, 99, 0);
        vs_hi();
        cmp_log("resume", log2, 2);
        chk("resume_eof", n_eof2, 1);
        chk("resume_rows", 32'(rows2), 1);

        // 3-byte pixels alongside 2-byte pixels on the same stream
        clear_logs(); vs_lo();
        m_lines = 2; lb[0] = 12; lb[1] = 13;
        send_line(0, 12, 99, 0);
        send_line(1, 13, 99, 0);
        vs_hi();
        cmp_log("b3", log3, 3);
        chk("b3_first", log3.size() > 0 ? log3[0].dat : 32'hDEAD_BEEF, {8'h0, bv(0, 0), bv(0, 1), bv(0, 2)});
        chk("b3_eof", n_eof3, 1);
        chk("b3_rows", 32'(rows3), 2);
        cmp_log("b2", log2, 2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
